// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Boot sequencer: receives a framed image, writes it to RAM at
//            LOAD_BASE, then releases the CPU and hands it the RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
    input  logic                  cpu_mem_read,
    input  logic                  cpu_mem_write,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data_out,
    output logic [DATA_WIDTH-1:0] cpu_mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int c_len_w = 2 * DATA_WIDTH;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_hdr_hi = 3'd1;
    localparam logic [2:0] c_st_hdr_lo = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_csum   = 3'd4;
    localparam logic [2:0] c_st_run    = 3'd5;
    localparam logic [2:0] c_st_error  = 3'd6;

    localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [c_len_w-1:0]    r_count;
    logic [c_len_w-1:0]    r_len;
    logic                  r_cpu_reset;

    logic                  w_receiving;
    logic                  w_accept;
    logic                  w_restart;
    logic                  w_last_data;
    logic [c_len_w-1:0]    w_full_len;
    logic [ADDR_WIDTH-1:0] w_load_addr;

    assign w_receiving = (r_state == c_st_hdr_hi) || (r_state == c_st_hdr_lo) ||
                         (r_state == c_st_data)   || (r_state == c_st_csum);
    assign w_accept    = rx_valid & w_receiving;
    assign w_restart   = start && ((r_state == c_st_idle) || (r_state == c_st_run) ||
                                   (r_state == c_st_error));
    assign w_full_len  = {r_len[c_len_w-1:DATA_WIDTH], rx_data};
    assign w_last_data = (r_count == (r_len - c_len_one));
    assign w_load_addr = LOAD_BASE + ADDR_WIDTH'(r_count);

    always_comb begin
        w_next_state = r_state;
        if (w_restart) begin
            w_next_state = c_st_hdr_hi;
        end else if (w_accept) begin
            case (r_state)
                c_st_hdr_hi: w_next_state = c_st_hdr_lo;
                c_st_hdr_lo: w_next_state = (w_full_len == '0) ? c_st_csum : c_st_data;
                c_st_data:   w_next_state = w_last_data ? c_st_csum : c_st_data;
                c_st_csum:   w_next_state = (rx_data == r_sum) ? c_st_run : c_st_error;
                default:     w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cpu_reset <= 1'b1;
            r_sum       <= '0;
            r_count     <= '0;
            r_len       <= '0;
        end else begin
            r_state     <= w_next_state;
            // Registered against the next state so it falls on the good-CSUM edge.
            r_cpu_reset <= (w_next_state != c_st_run);
            if (w_restart) begin
                r_sum   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                case (r_state)
                    c_st_hdr_hi: r_len[c_len_w-1:DATA_WIDTH] <= rx_data;
                    c_st_hdr_lo: r_len[DATA_WIDTH-1:0]       <= rx_data;
                    c_st_data: begin
                        r_sum   <= r_sum + rx_data;
                        r_count <= r_count + c_len_one;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_data_out    = '0;
        cpu_mem_data_in = '0;
        if (r_state == c_st_run) begin
            mem_address     = cpu_mem_address;
            mem_read        = cpu_mem_read;
            mem_write       = cpu_mem_write;
            mem_data_out    = cpu_mem_data_out;
            cpu_mem_data_in = mem_data_in;
        end else if ((r_state == c_st_data) && rx_valid) begin
            mem_address  = w_load_addr;
            mem_write    = 1'b1;
            mem_data_out = rx_data;
        end
    end

    assign rx_ready  = w_receiving;
    assign busy      = w_receiving;
    assign done      = (r_state == c_st_run);
    assign error     = (r_state == c_st_error);
    assign cpu_reset = r_cpu_reset;

endmodule
`default_nettype wire
